// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial lookahead adder.
package cla_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SLICES  = 8;
  localparam int unsigned SLICE_W = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
  } add_req_t;

endpackage

// File: rtl/cla_serial_add32_if.sv
// Request/result bundle between a requester and the serial adder.
interface cla_serial_add32_if;

  logic                      start;
  logic [cla_pkg::WIDTH-1:0] a;
  logic [cla_pkg::WIDTH-1:0] b;
  logic                      ci;
  logic                      busy;
  logic                      done;
  logic [cla_pkg::WIDTH-1:0] s;
  logic                      co;
  logic                      ovf;

  modport master (output start, a, b, ci, input busy, done, s, co, ovf);
  modport slave  (input start, a, b, ci, output busy, done, s, co, ovf);

endinterface

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: lookahead carries plus XOR3 sum bits.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               c3,
  output logic               co
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a | b;

  // Each carry is a flat sum of products; no internal ripple
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = a ^ b ^ c[SLICE_W-1:0];
  assign c3 = c[3];
  assign co = c[4];

endmodule

// File: rtl/cla_serial_add32.sv
// 32-bit adder evaluating one lookahead nibble per clock, LSB first, with start/busy/done framing.
module cla_serial_add32
  import cla_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  cla_serial_add32_if.slave bus
);

  state_t             state_q;
  state_t             state_d;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [WIDTH-1:0]   op_b_q;
  logic [WIDTH-1:0]   s_q;
  logic               co_q;
  logic               ovf_q;
  logic               load_c;
  logic               step_c;
  logic               last_c;
  logic [IDX_W-1:0]   base_c;
  logic [SLICE_W-1:0] nib_s;
  logic               nib_c3;
  logic               nib_co;
  add_req_t           req;

  assign req    = '{a: bus.a, b: bus.b, ci: bus.ci};
  assign last_c = (cnt_q == CNT_W'(SLICES - 1));
  assign base_c = IDX_W'(cnt_q * SLICE_W);

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls; start is only honoured outside RUN
  always_comb begin
    load_c = 1'b0;
    step_c = 1'b0;
    case (state_q)
      IDLE, DONE: load_c = bus.start;
      RUN:        step_c = 1'b1;
      default:    ;
    endcase
  end

  cla4_slice u_slice (
    .a  (op_a_q[base_c +: SLICE_W]),
    .b  (op_b_q[base_c +: SLICE_W]),
    .ci (carry_q),
    .s  (nib_s),
    .c3 (nib_c3),
    .co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load_c) begin
      op_a_q  <= req.a;
      op_b_q  <= req.b;
      carry_q <= req.ci;
      cnt_q   <= '0;
      s_q     <= '0;
    end else if (step_c) begin
      s_q[base_c +: SLICE_W] <= nib_s;
      carry_q                <= nib_co;
      cnt_q                  <= cnt_q + CNT_W'(1);
      // Top slice carries decide the 33rd bit and signed overflow
      if (last_c) begin
        co_q  <= nib_co;
        ovf_q <= nib_c3 ^ nib_co;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_serial_add32.sv
// Self-checking bench for cla_serial_add32 against an arithmetic reference model.
module tb_cla_serial_add32;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  cla_serial_add32_if bus ();

  cla_serial_add32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain 33-bit addition; signed overflow from operand/result signs
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                output logic [31:0] s, output logic co, output logic ovf);
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    s    = full[31:0];
    co   = full[32];
    ovf  = (a[31] == b[31]) && (full[31] != a[31]);
  endfunction

  // Called at a negedge; presents a request through the next rising edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic ci);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.ci    = ci;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts negedges after acceptance until done; cyc=0 on timeout
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.ci    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (bus.s !== 32'h0)   begin n_err++; $display("FAIL reset_s got %h exp 0", bus.s); end
    n_vec++; if (bus.co !== 1'b0)   begin n_err++; $display("FAIL reset_co got %b exp 0", bus.co); end
    n_vec++; if (bus.ovf !== 1'b0)  begin n_err++; $display("FAIL reset_ovf got %b exp 0", bus.ovf); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
    bus.start = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_no_start busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_ripple();
    logic [31:0] es; logic eco, eovf; int cyc, bc;
    model(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, es, eco, eovf);
    launch(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc, bc);
    n_vec++; if (cyc != 9)  begin n_err++; $display("FAIL ripple_latency got %0d exp 9", cyc); end
    n_vec++; if (bc != 8)   begin n_err++; $display("FAIL ripple_busy_cycles got %0d exp 8", bc); end
    n_vec++; if (bus.s !== es || es !== 32'h0) begin n_err++; $display("FAIL ripple_s got %h exp %h", bus.s, es); end
    n_vec++; if (bus.co !== eco)  begin n_err++; $display("FAIL ripple_co got %b exp %b", bus.co, eco); end
    n_vec++; if (bus.ovf !== eovf) begin n_err++; $display("FAIL ripple_ovf got %b exp %b", bus.ovf, eovf); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ripple_busy_at_done got %b exp 0", bus.busy); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL ripple_done_pulse got %b exp 0", bus.done); end
    n_vec++; if (bus.s !== es) begin n_err++; $display("FAIL ripple_hold_s got %h exp %h", bus.s, es); end
  endtask

  task automatic test_overflow();
    logic [31:0] va [2]; logic [31:0] vb [2]; logic vc [2];
    logic [31:0] es; logic eco, eovf; int cyc, bc;
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
    va[1] = 32'h1234_5678; vb[1] = 32'h8765_4321; vc[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model(va[k], vb[k], vc[k], es, eco, eovf);
      launch(va[k], vb[k], vc[k]);
      wait_done(cyc, bc);
      n_vec++; if (cyc != 9) begin n_err++; $display("FAIL ovf%0d_latency got %0d exp 9", k, cyc); end
      n_vec++; if (bus.s !== es) begin n_err++; $display("FAIL ovf%0d_s got %h exp %h", k, bus.s, es); end
      n_vec++; if (bus.co !== eco) begin n_err++; $display("FAIL ovf%0d_co got %b exp %b", k, bus.co, eco); end
      n_vec++; if (bus.ovf !== eovf) begin n_err++; $display("FAIL ovf%0d_ovf got %b exp %b", k, bus.ovf, eovf); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] a, b, es; logic eco, eovf; int dcnt, first;
    a = $urandom; b = $urandom;
    model(a, b, 1'b0, es, eco, eovf);
    launch(a, b, 1'b0);
    dcnt = 0; first = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.start = 1'b1; bus.a = ~a; bus.b = a ^ b; bus.ci = 1'b1;
      end else if (i == 4) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dcnt++;
        if (first == 0) first = i;
      end
    end
    n_vec++; if (first != 9) begin n_err++; $display("FAIL ignore_latency got %0d exp 9", first); end
    n_vec++; if (dcnt != 1)  begin n_err++; $display("FAIL ignore_done_count got %0d exp 1", dcnt); end
    n_vec++; if (bus.s !== es) begin n_err++; $display("FAIL ignore_s got %h exp %h", bus.s, es); end
    n_vec++; if (bus.co !== eco) begin n_err++; $display("FAIL ignore_co got %b exp %b", bus.co, eco); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, es1, es2; logic c1, eco1, eovf1, eco2, eovf2; int cyc, bc;
    a1 = $urandom; b1 = $urandom; c1 = 1'b1;
    a2 = $urandom; b2 = $urandom;
    model(a1, b1, c1, es1, eco1, eovf1);
    model(a2, b2, 1'b0, es2, eco2, eovf2);
    launch(a1, b1, c1);
    for (int i = 1; i <= 8; i++) @(negedge clk);
    bus.start = 1'b1; bus.a = a2; bus.b = b2; bus.ci = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b exp 1", bus.done); end
    n_vec++; if (bus.s !== es1) begin n_err++; $display("FAIL b2b_first_s got %h exp %h", bus.s, es1); end
    n_vec++; if (bus.co !== eco1 || bus.ovf !== eovf1) begin
      n_err++; $display("FAIL b2b_first_flags got co=%b ovf=%b exp co=%b ovf=%b", bus.co, bus.ovf, eco1, eovf1);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, bc);
    n_vec++; if (cyc != 9) begin n_err++; $display("FAIL b2b_spacing got %0d exp 9", cyc); end
    n_vec++; if (bc != 8)  begin n_err++; $display("FAIL b2b_busy_cycles got %0d exp 8", bc); end
    n_vec++; if (bus.s !== es2) begin n_err++; $display("FAIL b2b_second_s got %h exp %h", bus.s, es2); end
    n_vec++; if (bus.co !== eco2 || bus.ovf !== eovf2) begin
      n_err++; $display("FAIL b2b_second_flags got co=%b ovf=%b exp co=%b ovf=%b", bus.co, bus.ovf, eco2, eovf2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] es; logic eco, eovf; int cyc, bc;
    launch(32'hFFFF_0000, 32'h0001_FFFF, 1'b0);
    for (int i = 1; i <= 5; i++) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    n_vec++; if (bus.s !== 32'h0 || bus.co !== 1'b0 || bus.ovf !== 1'b0) begin
      n_err++; $display("FAIL midrst_data got s=%h co=%b ovf=%b exp 0 0 0", bus.s, bus.co, bus.ovf);
    end
    model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, es, eco, eovf);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc, bc);
    n_vec++; if (cyc != 9) begin n_err++; $display("FAIL midrst_latency got %0d exp 9", cyc); end
    n_vec++; if (bus.s !== es || es !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL midrst_s got %h exp %h", bus.s, es); end
    n_vec++; if (bus.co !== eco || bus.ovf !== eovf) begin
      n_err++; $display("FAIL midrst_flags got co=%b ovf=%b exp co=%b ovf=%b", bus.co, bus.ovf, eco, eovf);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b, es; logic c, eco, eovf; int cyc, bc, gap;
    for (int k = 0; k < 24; k++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(1, 0));
      if (k % 4 == 0) b = ~a;
      model(a, b, c, es, eco, eovf);
      launch(a, b, c);
      wait_done(cyc, bc);
      n_vec++; if (cyc != 9 || bus.s !== es || bus.co !== eco || bus.ovf !== eovf) begin
        n_err++;
        $display("FAIL rand%0d got cyc=%0d s=%h co=%b ovf=%b exp cyc=9 s=%h co=%b ovf=%b",
                 k, cyc, bus.s, bus.co, bus.ovf, es, eco, eovf);
      end
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;
    reset_n   = 1'b0;
    test_reset();
    test_ripple();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
